// File: rtl/register_file_pkg.sv
// register_file_pkg: shared FSM state type for the multiport register file
package register_file_pkg;
   typedef enum logic [0:0] {RF_IDLE = 1'b0, RF_CLEAR = 1'b1} rf_state_t;
endpackage

// File: rtl/register_file_write_arbiter.sv
// register_file_write_arbiter: per-register merge of write ports, highest port wins
module register_file_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int WRITE_PORTS = 1,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W = $clog2(REG_COUNT)
) (
   input logic [WRITE_PORTS-1:0] write_enable,
   input logic [WRITE_PORTS-1:0][ADDR_W-1:0] write_selector,
   input logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_value,
   output logic [REG_COUNT-1:0] reg_enable,
   output logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_value,
   output logic conflict
);
   always_comb begin
      reg_enable = '0;
      reg_value = '0;
      conflict = 1'b0;
      for (int r = 0; r < REG_COUNT; r++)
         for (int p = 0; p < WRITE_PORTS; p++)
            if (write_enable[p] && write_selector[p] == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0)) begin
               conflict = conflict | reg_enable[r];
               reg_enable[r] = 1'b1;
               reg_value[r] = write_value[p];
            end
   end
endmodule

// File: rtl/register_file_multiport.sv
// register_file_multiport: parametrised N-read/M-write register file with bypass and clear sweep
module register_file_multiport
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int READ_PORTS = 2,
   parameter int WRITE_PORTS = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS = 1,
   localparam int ADDR_W = $clog2(REG_COUNT)
) (
   input logic clock,
   input logic reset_n,
   input logic clear_request,
   output logic busy,
   input logic [WRITE_PORTS-1:0] write_enable,
   input logic [WRITE_PORTS-1:0][ADDR_W-1:0] write_selector,
   input logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_value,
   input logic [READ_PORTS-1:0][ADDR_W-1:0] read_selector,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] read_value,
   output logic write_conflict
);
   rf_state_t state;
   logic [ADDR_W-1:0] index;
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [WRITE_PORTS-1:0] enable_gated;
   logic [REG_COUNT-1:0] reg_enable;
   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_value;
   logic [READ_PORTS-1:0][DATA_WIDTH-1:0] next_read;
   logic conflict;
   // writes are dropped during a sweep and in the cycle that launches one
   assign enable_gated = write_enable & {WRITE_PORTS{state == RF_IDLE && !clear_request}};
   assign busy = state == RF_CLEAR;
   register_file_write_arbiter #(
      .DATA_WIDTH(DATA_WIDTH),
      .REG_COUNT(REG_COUNT),
      .WRITE_PORTS(WRITE_PORTS),
      .ZERO_REG(ZERO_REG),
      .ADDR_W(ADDR_W)
   ) u_arbiter (
      .write_enable(enable_gated),
      .write_selector(write_selector),
      .write_value(write_value),
      .reg_enable(reg_enable),
      .reg_value(reg_value),
      .conflict(conflict)
   );
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= RF_CLEAR;
         index <= '0;
      end else if (state == RF_CLEAR) begin
         index <= index + 1'b1;
         if (index == ADDR_W'(REG_COUNT - 1)) state <= RF_IDLE;
      end else if (clear_request) begin
         state <= RF_CLEAR;
         index <= '0;
      end
   always_ff @(posedge clock)
      if (state == RF_CLEAR) regs[index] <= '0;
      else
         for (int r = 0; r < REG_COUNT; r++)
            if (reg_enable[r]) regs[r] <= reg_value[r];
   always_comb begin
      next_read = '0;
      for (int p = 0; p < READ_PORTS; p++)
         next_read[p] = (state == RF_CLEAR || (ZERO_REG != 0 && read_selector[p] == '0)) ? '0 :
                        (BYPASS != 0 && reg_enable[read_selector[p]]) ? reg_value[read_selector[p]] :
                        regs[read_selector[p]];
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         read_value <= '0;
         write_conflict <= 1'b0;
      end else begin
         read_value <= next_read;
         write_conflict <= conflict;
      end
endmodule
